// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of the two-port data memory arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;
  logic                  rsp0_err;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;
  logic                  rsp1_err;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp0_err,
    output rsp1_valid, rsp1_rdata, rsp1_err,
    output mem_read_en, mem_write_en, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp0_err,
    input  rsp1_valid, rsp1_rdata, rsp1_err,
    input  mem_read_en, mem_write_en, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-cycle data memory.
// One IDLE (grant) cycle plus one ACCESS cycle per transfer.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 1024
) (
  input  logic           clock,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACCESS} state_e;

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] THREE = (ADDR_WIDTH+1)'(3);

  state_e state_q, state_d;

  logic                  last_grant_q, last_grant_d;
  logic                  port_q, port_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic                  rsp0_err_q, rsp0_err_d;
  logic                  rsp1_err_q, rsp1_err_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic                  gnt0, gnt1, accept;
  logic                  sel_we, sel_err;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH:0]   end_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  // state register
  always_ff @(posedge clock) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant outputs; on a tie the port not granted last wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
      gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    end
  end

  assign accept         = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;

  // one extra bit so addr + 3 cannot wrap past the top of the address space
  assign end_addr = {1'b0, sel_addr} + THREE;
  assign sel_err  = (sel_addr[1:0] != 2'b00) | (end_addr >= LIMIT);

  assign rd_word = (!we_q && !err_q) ? bus.mem_rdata : '0;

  always_comb begin
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    err_d        = err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    if (accept) begin
      last_grant_d = gnt1;
      port_d       = gnt1;
      we_d         = sel_we;
      err_d        = sel_err;
      mem_addr_d   = sel_addr;
      mem_wdata_d  = sel_wdata;
      mem_re_d     = ~sel_we & ~sel_err;
      mem_we_d     = sel_we & ~sel_err;
    end
  end

  always_comb begin
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (state_q == ACCESS) begin
      if (port_q) begin
        rsp1_valid_d = 1'b1;
        rsp1_err_d   = err_q;
        rsp1_rdata_d = rd_word;
      end else begin
        rsp0_valid_d = 1'b1;
        rsp0_err_d   = err_q;
        rsp0_rdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      err_q        <= err_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign bus.mem_read_en  = mem_re_q;
  assign bus.mem_write_en = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp0_err     = rsp0_err_q;
  assign bus.rsp1_err     = rsp1_err_q;
  assign bus.rsp0_rdata   = rsp0_rdata_q;
  assign bus.rsp1_rdata   = rsp1_rdata_q;

endmodule
